// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, the NOP word used for pipeline flushes,
// and the branch-displacement sign extension used by the fetch stage.
package cpu_pkg;

    localparam int          PC_W_DEFAULT = 16;
    localparam logic [15:0] NOP_INST     = 16'h0020;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fetch_state_e;

    function automatic logic [PC_W_DEFAULT-1:0] sext8(input logic [7:0] disp);
        return {{(PC_W_DEFAULT-8){disp[7]}}, disp};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: synchronous IMEM port plus the decoder-facing instruction/redirect signals.
interface fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
);
    logic            bcond_i;
    logic            jcond_i;
    logic [7:0]      disp_i;
    logic [PC_W-1:0] jtarget_i;
    logic [15:0]     imem_rdata_i;
    logic [PC_W-1:0] imem_addr_o;
    logic            imem_en_o;
    logic [15:0]     inst_o;
    logic [PC_W-1:0] link_o;

    modport master (
        input  bcond_i, jcond_i, disp_i, jtarget_i, imem_rdata_i,
        output imem_addr_o, imem_en_o, inst_o, link_o
    );

    modport slave (
        output bcond_i, jcond_i, disp_i, jtarget_i, imem_rdata_i,
        input  imem_addr_o, imem_en_o, inst_o, link_o
    );
endinterface

// File: rtl/fetch_unit_pc_next_calc.sv
// Next-PC selection: register jump beats PC-relative branch beats sequential increment.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic            bcond,
    input  logic            jcond,
    input  logic [7:0]      disp,
    input  logic [PC_W-1:0] jtarget,
    input  logic [PC_W-1:0] pc_q,
    input  logic [PC_W-1:0] pc_d,
    output logic [PC_W-1:0] next_pc,
    output logic            redirect
);

    logic [PC_W-1:0] disp_ext;

    generate
        if (PC_W == PC_W_DEFAULT) begin : g_pkg_sext
            assign disp_ext = sext8(disp);
        end else begin : g_wide_sext
            assign disp_ext = {{(PC_W-8){disp[7]}}, disp};
        end
    endgenerate

    always_comb begin
        next_pc  = pc_q + PC_W'(1);
        redirect = bcond | jcond;
        if (jcond) begin
            next_pc = jtarget;
        end else if (bcond) begin
            // Branches are relative to the instruction being decoded, not the fetch PC.
            next_pc = pc_d + disp_ext;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives synchronous IMEM and feeds the decoder.
// A decoder redirect squashes the single wrong-path word fetched during the redirect cycle.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [15:0]     NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start_i,
    input  logic         stall_i,
    input  logic         scan_en_i,
    input  logic         scan_i,
    output logic         scan_o,
    output logic         running_o,
    fetch_unit_if.master bus
);

    fetch_state_e    state_reg, state_next;
    logic [PC_W-1:0] pc_q, pc_f, pc_d;
    logic            squash_q;
    logic            scan_q;
    logic [PC_W-1:0] next_pc;
    logic            redirect;

    pc_next_calc #(.PC_W(PC_W)) u_pc_next (
        .bcond    (bus.bcond_i),
        .jcond    (bus.jcond_i),
        .disp     (bus.disp_i),
        .jtarget  (bus.jtarget_i),
        .pc_q     (pc_q),
        .pc_d     (pc_d),
        .next_pc  (next_pc),
        .redirect (redirect)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A redirect keeps the stage in RUN; a concurrent stall only bites next cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_i && !scan_en_i) state_next = RUN;
            RUN:     if (stall_i && !redirect)  state_next = STALL;
            STALL:   if (!stall_i)              state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q     <= RESET_PC;
            pc_f     <= RESET_PC;
            pc_d     <= RESET_PC;
            squash_q <= 1'b1;
            scan_q   <= 1'b0;
        end else begin
            scan_q <= pc_q[PC_W-1];
            case (state_reg)
                IDLE: begin
                    if (scan_en_i) begin
                        pc_q <= {pc_q[PC_W-2:0], scan_i};
                    end else if (start_i) begin
                        // IMEM has produced nothing yet for the first RUN cycle.
                        squash_q <= 1'b1;
                    end
                end
                RUN: begin
                    pc_d     <= pc_f;
                    pc_f     <= pc_q;
                    pc_q     <= next_pc;
                    squash_q <= redirect;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.imem_en_o = 1'b0;
        bus.inst_o    = NOP_INST;
        if (state_reg == RUN) begin
            bus.imem_en_o = 1'b1;
        end
        // In STALL the IMEM is disabled, so rdata (and hence inst_o) holds.
        if (state_reg != IDLE && !squash_q) begin
            bus.inst_o = bus.imem_rdata_i;
        end
    end

    assign bus.imem_addr_o = pc_q;
    assign bus.link_o      = pc_d + PC_W'(1);
    assign scan_o          = scan_q;
    assign running_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// checked against a cycle-level model of the fetch rules and a synchronous IMEM.
module tb_fetch_unit;

    localparam logic [15:0] NOP     = 16'h0020;
    localparam int          M_IDLE  = 0;
    localparam int          M_RUN   = 1;
    localparam int          M_STALL = 2;

    logic clk = 1'b0;
    logic rstn, start_i, stall_i, scan_en_i, scan_i, scan_o, running_o;

    fetch_unit_if #(.PC_W(16)) bus ();

    fetch_unit #(.PC_W(16), .RESET_PC(16'h0000), .NOP_INST(16'h0020)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start_i   (start_i),
        .stall_i   (stall_i),
        .scan_en_i (scan_en_i),
        .scan_i    (scan_i),
        .scan_o    (scan_o),
        .running_o (running_o),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h1234;
    endfunction

    always @(posedge clk) begin
        if (bus.imem_en_o) bus.imem_rdata_i <= word_at(bus.imem_addr_o);
    end

    // Reference model: next fetch address, address whose data is on rdata,
    // address in the decoder, kill flag for the word presented, mode, scan-out bit.
    logic [15:0] m_pc, m_f, m_d;
    logic        m_sq, m_scan;
    int          m_mode;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic model_reset();
        m_pc = 16'h0000; m_f = 16'h0000; m_d = 16'h0000;
        m_sq = 1'b1; m_scan = 1'b0; m_mode = M_IDLE;
    endtask

    task automatic model_step();
        logic        old_msb;
        logic [15:0] tgt;
        old_msb = m_pc[15];
        if (m_mode == M_IDLE) begin
            if (scan_en_i) m_pc = (m_pc << 1) | 16'(scan_i);
            else if (start_i) begin m_mode = M_RUN; m_sq = 1'b1; end
        end else if (m_mode == M_RUN) begin
            if (bus.jcond_i)      tgt = bus.jtarget_i;
            else if (bus.bcond_i) tgt = 16'(int'(m_d) + int'($signed(bus.disp_i)));
            else                  tgt = m_pc + 16'd1;
            m_d  = m_f;
            m_f  = m_pc;
            m_pc = tgt;
            m_sq = bus.jcond_i || bus.bcond_i;
            if (stall_i && !m_sq) m_mode = M_STALL;
        end else begin
            if (!stall_i) m_mode = M_RUN;
        end
        m_scan = old_msb;
    endtask

    function automatic logic [50:0] exp_vec();
        logic [15:0] e_inst;
        e_inst = (m_mode == M_IDLE || m_sq) ? NOP : word_at(m_f);
        return {m_pc, (m_mode == M_RUN), e_inst, m_d + 16'd1, (m_mode != M_IDLE), m_scan};
    endfunction

    function automatic logic [50:0] act_vec();
        return {bus.imem_addr_o, bus.imem_en_o, bus.inst_o, bus.link_o, running_o, scan_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        start_i = 0; stall_i = 0; scan_en_i = 0; scan_i = 0;
        bus.bcond_i = 0; bus.jcond_i = 0; bus.disp_i = 8'h00; bus.jtarget_i = 16'h0000;
    endtask

    // Pulls rstn low between clock edges; leaves it low for the caller to check.
    task automatic assert_reset_midcycle();
        #2 rstn = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (act_vec() !== exp_vec()) $display("FAIL reset_vec: got %h required %h", act_vec(), exp_vec()); else n_pass++;
        n_checks++; if (bus.inst_o !== NOP) $display("FAIL reset_inst: got %h required %h", bus.inst_o, NOP); else n_pass++;
        n_checks++; if (bus.link_o !== 16'h0001) $display("FAIL reset_link: got %h required 0001", bus.link_o); else n_pass++;
        #2 rstn = 1'b1;
        tick();
        n_checks++; if (act_vec() !== exp_vec()) $display("FAIL reset_idle: got %h required %h", act_vec(), exp_vec()); else n_pass++;
    endtask

    task automatic test_scan_start();
        logic [15:0] v;
        v = 16'h0010;
        scan_en_i = 1;
        for (int i = 15; i >= 0; i--) begin
            scan_i = v[i];
            start_i = (i == 3);
            tick();
            n_checks++; if (act_vec() !== exp_vec()) $display("FAIL scan_vec bit=%0d: got %h required %h", i, act_vec(), exp_vec()); else n_pass++;
        end
        scan_en_i = 0; scan_i = 0;
        n_checks++; if (bus.imem_addr_o !== 16'h0010 || bus.imem_en_o !== 1'b0) $display("FAIL scan_loaded: got addr=%h en=%b required 0010/0", bus.imem_addr_o, bus.imem_en_o); else n_pass++;
        start_i = 1;
        tick();
        start_i = 0;
        n_checks++; if (bus.imem_addr_o !== 16'h0010 || bus.inst_o !== NOP || running_o !== 1'b1) $display("FAIL start_first: got addr=%h inst=%h run=%b required 0010/0020/1", bus.imem_addr_o, bus.inst_o, running_o); else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++; if (bus.imem_addr_o !== 16'h0010 + 16'(k)) $display("FAIL start_seq k=%0d: got %h required %h", k, bus.imem_addr_o, 16'h0010 + 16'(k)); else n_pass++;
            n_checks++; if (act_vec() !== exp_vec()) $display("FAIL start_vec k=%0d: got %h required %h", k, act_vec(), exp_vec()); else n_pass++;
        end
    endtask

    task automatic test_branch();
        int cnt;
        cnt = 0;
        while (m_d != 16'h0020 && cnt < 40) begin
            tick(); cnt++;
            n_checks++; if (act_vec() !== exp_vec()) $display("FAIL branch_run: got %h required %h", act_vec(), exp_vec()); else n_pass++;
        end
        n_checks++; if (cnt >= 40) $display("FAIL branch_reach: got %0d cycles required <40", cnt); else n_pass++;
        bus.bcond_i = 1; bus.disp_i = 8'hFC;
        tick();
        bus.bcond_i = 0; bus.disp_i = 8'h00;
        n_checks++; if (bus.imem_addr_o !== 16'h001C || bus.inst_o !== NOP) $display("FAIL branch_redirect: got addr=%h inst=%h required 001c/0020", bus.imem_addr_o, bus.inst_o); else n_pass++;
        tick();
        n_checks++; if (bus.inst_o !== word_at(16'h001C)) $display("FAIL branch_target_word: got %h required %h", bus.inst_o, word_at(16'h001C)); else n_pass++;
        n_checks++; if (act_vec() !== exp_vec()) $display("FAIL branch_vec: got %h required %h", act_vec(), exp_vec()); else n_pass++;
    endtask

    task automatic test_jump_priority();
        logic [15:0] e_link;
        bus.jcond_i = 1; bus.bcond_i = 1; bus.disp_i = 8'h05; bus.jtarget_i = 16'h0100;
        e_link = m_d + 16'd1;
        n_checks++; if (bus.link_o !== e_link) $display("FAIL jal_link: got %h required %h", bus.link_o, e_link); else n_pass++;
        tick();
        clear_inputs();
        n_checks++; if (bus.imem_addr_o !== 16'h0100) $display("FAIL jump_wins: got %h required 0100", bus.imem_addr_o); else n_pass++;
        tick();
        n_checks++; if (act_vec() !== exp_vec()) $display("FAIL jump_vec: got %h required %h", act_vec(), exp_vec()); else n_pass++;
    endtask

    task automatic test_stall();
        logic [15:0] hold_addr, hold_inst;
        stall_i = 1;
        tick();
        hold_addr = m_pc;
        hold_inst = (m_sq) ? NOP : word_at(m_f);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (bus.imem_en_o !== 1'b0 || bus.imem_addr_o !== hold_addr || bus.inst_o !== hold_inst) $display("FAIL stall_hold k=%0d: got en=%b addr=%h inst=%h required 0/%h/%h", k, bus.imem_en_o, bus.imem_addr_o, bus.inst_o, hold_addr, hold_inst); else n_pass++;
        end
        stall_i = 0;
        tick();
        n_checks++; if (bus.imem_en_o !== 1'b1 || bus.imem_addr_o !== hold_addr) $display("FAIL stall_resume: got en=%b addr=%h required 1/%h", bus.imem_en_o, bus.imem_addr_o, hold_addr); else n_pass++;
        tick();
        n_checks++; if (bus.imem_addr_o !== hold_addr + 16'd1) $display("FAIL stall_next: got %h required %h", bus.imem_addr_o, hold_addr + 16'd1); else n_pass++;
        n_checks++; if (act_vec() !== exp_vec()) $display("FAIL stall_vec: got %h required %h", act_vec(), exp_vec()); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [15:0] pat [2];
        int cnt;
        assert_reset_midcycle();
        #1 rstn = 1'b1;
        pat[0] = 16'hA5A5; pat[1] = 16'hFFFE;
        scan_en_i = 1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 15; i >= 0; i--) begin
                scan_i = pat[p][i];
                tick();
                n_checks++; if (act_vec() !== exp_vec()) $display("FAIL wrap_scan p=%0d bit=%0d: got %h required %h", p, i, act_vec(), exp_vec()); else n_pass++;
            end
        end
        scan_en_i = 0; scan_i = 0; start_i = 1;
        tick();
        start_i = 0;
        tick();
        tick();
        n_checks++; if (bus.imem_addr_o !== 16'h0000) $display("FAIL wrap_seq: got %h required 0000", bus.imem_addr_o); else n_pass++;
        cnt = 0;
        while (m_d != 16'h0002 && cnt < 20) begin tick(); cnt++; end
        n_checks++; if (cnt >= 20) $display("FAIL wrap_reach: got %0d cycles required <20", cnt); else n_pass++;
        bus.bcond_i = 1; bus.disp_i = 8'h80;
        tick();
        clear_inputs();
        n_checks++; if (bus.imem_addr_o !== 16'hFF82) $display("FAIL wrap_branch: got %h required ff82", bus.imem_addr_o); else n_pass++;
    endtask

    task automatic test_async_reset();
        tick();
        assert_reset_midcycle();
        n_checks++; if (act_vec() !== exp_vec() || running_o !== 1'b0 || bus.imem_en_o !== 1'b0) $display("FAIL async_reset: got %h required %h", act_vec(), exp_vec()); else n_pass++;
        #1 rstn = 1'b1;
        bus.bcond_i = 1; bus.jcond_i = 1; stall_i = 1; bus.jtarget_i = 16'h4321;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (running_o !== 1'b0 || bus.imem_en_o !== 1'b0 || act_vec() !== exp_vec()) $display("FAIL idle_ignore k=%0d: got %h required %h", k, act_vec(), exp_vec()); else n_pass++;
        end
        clear_inputs();
        start_i = 1;
        tick();
        start_i = 0;
        n_checks++; if (running_o !== 1'b1 || bus.imem_addr_o !== 16'h0000) $display("FAIL restart: got run=%b addr=%h required 1/0000", running_o, bus.imem_addr_o); else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.bcond_i    = ($urandom_range(7) == 0);
            bus.jcond_i    = ($urandom_range(11) == 0);
            bus.disp_i     = 8'($urandom);
            bus.jtarget_i  = 16'($urandom);
            stall_i        = ($urandom_range(4) == 0);
            scan_en_i      = ($urandom_range(3) == 0);
            scan_i         = 1'($urandom);
            start_i        = 1'($urandom);
            if ($urandom_range(79) == 0) begin
                assert_reset_midcycle();
                n_checks++; if (act_vec() !== exp_vec()) $display("FAIL rand_reset c=%0d: got %h required %h", c, act_vec(), exp_vec()); else n_pass++;
                #1 rstn = 1'b1;
            end
            tick();
            n_checks++; if (act_vec() !== exp_vec()) $display("FAIL rand_vec c=%0d: got %h required %h", c, act_vec(), exp_vec()); else n_pass++;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_scan_start();
        test_branch();
        test_jump_priority();
        test_stall();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Owns the PC and drives the synchronous IMEM address/enable.
- Forwards IMEM read data to the decoder's instruction input. A squashed word is replaced by NOP.
- Consumes the decoder's bcond/jcond redirects. Supplies the JAL link value and a scannable start PC.

Parameters:
- PC_W, 16: PC / IMEM address width (word-addressed).
- RESET_PC, 0: PC value loaded on reset.
- NOP_INST, 16'h0020: word substituted for squashed fetches.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start_i  in  1  leave IDLE and begin fetching at current PC
- stall_i  in  1  freeze fetch (PC, pipeline PCs, squash state)
- bcond_i  in  1  decoder: taken PC-relative branch
- jcond_i  in  1  decoder: taken register jump (includes JAL)
- disp_i  in  8  decoder imm_o; signed branch displacement
- jtarget_i  in  PC_W  register-file value of jump target register
- imem_rdata_i  in  16  synchronous IMEM read data (address from previous enabled cycle)
- scan_en_i  in  1  shift PC scan chain
- scan_i  in  1  scan in (into PC LSB)
- scan_o  out  1  scan out (PC MSB)
- imem_addr_o  out  PC_W  IMEM address (= pc_q)
- imem_en_o  out  1  IMEM read enable
- inst_o  out  16  to decoder inst_i
- link_o  out  PC_W  pc_d + 1, return address for JAL
- running_o  out  1  FSM not in IDLE

Behaviour:
- Registers:
  - pc_q: next address to fetch.
  - pc_f: address whose data is on imem_rdata_i.
  - pc_d: address of the word in the decoder IR.
  - squash_q: 1-bit flag.
  - state.
- Reset (async, rstn=0):
  - pc_q=RESET_PC; pc_f=pc_d=RESET_PC; squash_q=1; state=IDLE.
  - Outputs: imem_en_o=0, inst_o=NOP_INST, running_o=0, scan_o=0, link_o=RESET_PC+1.
- FSM states: IDLE, RUN, STALL.
  - IDLE: imem_en_o=0, inst_o=NOP_INST; PC holds.
    - If scan_en_i=1: pc_q shifts left, scan_i into bit 0, scan_o=pc_q[PC_W-1] registered.
    - start_i=1 and scan_en_i=0 -> RUN, with squash_q=1 (first IMEM data not yet valid).
  - RUN: imem_en_o=1, imem_addr_o=pc_q. Each cycle:
    - pc_d<=pc_f; pc_f<=pc_q; pc_q<=next_pc.
    - stall_i=1 and no redirect -> STALL.
  - STALL: imem_en_o=0 (IMEM holds rdata); all PC/squash registers hold; inst_o holds last value.
    - stall_i=0 -> RUN.
- inst_o = squash_q ? NOP_INST : imem_rdata_i.
- next_pc:
  - jcond_i=1 -> jtarget_i.
  - else bcond_i=1 -> pc_d + sext(disp_i), mod 2^PC_W.
  - else pc_q + 1, wrapping at 2^PC_W.
- Redirect (bcond_i|jcond_i):
  - squash_q<=1 for exactly the following cycle. This kills the wrong-path word pc_q fetched during the redirect cycle.
  - The decoder NOPs the word already on rdata.
  - Otherwise squash_q<=0.
- Priority:
  - jcond_i over bcond_i.
  - Redirect over stall_i: the redirect is applied and state stays RUN; the stall takes effect next cycle.
- Redirects and stall_i are ignored in IDLE.
- Scan is ignored outside IDLE; scan_o still shifts pc_q[PC_W-1].
- link_o = pc_d + 1, combinational from pc_d.
- Reset mid-operation: immediate return to IDLE with reset values; no IMEM access until start_i.

Decomposition:
- Shared package cpu_pkg holds:
  - NOP_INST constant (shared with the decoder flush).
  - fetch_state_e enum (IDLE, RUN, STALL).
  - PC_W default.
  - function sext8(disp) -> PC_W.
- One natural sub-module: pc_next_calc (combinational next_pc mux/adder).

Test Plan:
- Reset, scan in 16'h0010, start_i -> imem_addr_o 0x10,0x11,0x12…; first inst_o after start = 16'h0020; link_o tracks pc_d+1.
- bcond_i=1, disp_i=8'hFC, pc_d=0x20 -> next imem_addr_o=0x1C; inst_o=NOP_INST for exactly one cycle; then the word at 0x1C appears.
- jcond_i=1 and bcond_i=1 together, jtarget_i=0x0100 -> imem_addr_o=0x0100 (jump wins); link_o=pc_d+1 in that cycle.
- stall_i high 3 cycles in RUN -> imem_en_o=0, imem_addr_o and inst_o constant; resume continues at the next sequential address with no skip or duplicate.
- pc_q=0xFFFF sequential -> next address 0x0000; bcond with pc_d=0x0002, disp=8'h80 -> 0xFF82.
- rstn pulsed low mid-RUN, asynchronously between clock edges -> outputs immediately reset; stays IDLE ignoring bcond_i/stall_i until start_i.
